round_sequencer: RTL

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/round_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// round_sequencer: round FSM (IDLE/GEN/RUN/END/OVER) with a pausable, prescaled round timer.
// Define ROUND_SEQ_SPEEDUP_EN to shorten the round limit after every won round.
module round_sequencer #(
    parameter int TIMER_WIDTH  = 8,
    parameter int ROUND_TICKS  = 200,
    parameter int TICK_DIV     = 1000,
    parameter int SPEEDUP_STEP = 10,
    parameter int MIN_TICKS    = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_pause,
    output logic                   o_gen_start,
    input  logic                   i_gen_done,
    input  logic                   i_in_safe_zone,
    input  logic                   i_player_hit,
    output logic                   o_round_ended,
    output logic                   o_is_win,
    output logic [TIMER_WIDTH-1:0] o_time_left,
    output logic                   o_running,
    output logic [2:0]             o_state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GEN  = 3'd1,
        S_RUN  = 3'd2,
        S_END  = 3'd3,
        S_OVER = 3'd4
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [TIMER_WIDTH-1:0] LIMIT_INIT = TIMER_WIDTH'(ROUND_TICKS);
`ifdef ROUND_SEQ_SPEEDUP_EN
    localparam logic [TIMER_WIDTH-1:0] MIN_L  = TIMER_WIDTH'(MIN_TICKS);
    localparam logic [TIMER_WIDTH-1:0] STEP_L = TIMER_WIDTH'(SPEEDUP_STEP);
    localparam logic [TIMER_WIDTH:0]   FLOOR_AT = (TIMER_WIDTH+1)'(MIN_TICKS + SPEEDUP_STEP);
`endif

    if (TICK_DIV < 2 || ROUND_TICKS < 1 || MIN_TICKS < 1 || SPEEDUP_STEP < 0) begin : g_bad_cfg
        $error("round_sequencer: invalid parameter set");
    end

    state_t                 state_q, state_d;
    logic [PW-1:0]          presc_q;
    logic [TIMER_WIDTH-1:0] limit_q;
    logic                   run_act, tick, end_now, won;

    always_comb begin
        run_act = state_q == S_RUN && !i_pause;
        tick    = run_act && presc_q == PW'(TICK_DIV - 1);
        end_now = run_act && (i_player_hit || i_in_safe_zone || o_time_left == '0);
        won     = !i_player_hit && i_in_safe_zone;
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = i_start ? S_GEN : S_IDLE;
            S_GEN:   state_d = i_gen_done ? S_RUN : S_GEN;
            S_RUN:   state_d = end_now ? S_END : S_RUN;
            S_END:   state_d = o_is_win ? S_GEN : S_OVER;
            S_OVER:  state_d = i_start ? S_GEN : S_OVER;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // o_is_win is written on entry to END so END can route on it directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_gen_start   <= 1'b0;
            o_round_ended <= 1'b0;
            o_is_win      <= 1'b0;
            o_time_left   <= '0;
            presc_q       <= '0;
            limit_q       <= LIMIT_INIT;
        end else begin
            o_gen_start   <= state_d == S_GEN && state_q != S_GEN;
            o_round_ended <= state_d == S_END;
            if (state_d == S_END) o_is_win <= won;
            if (state_q == S_GEN && i_gen_done) begin
                o_time_left <= limit_q;
                presc_q     <= '0;
            end else if (run_act) begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
                if (tick && o_time_left != '0) o_time_left <= o_time_left - 1'b1;
            end
            if (state_q == S_OVER && i_start) limit_q <= LIMIT_INIT;
`ifdef ROUND_SEQ_SPEEDUP_EN
            else if (state_q == S_END && o_is_win)
                limit_q <= ({1'b0, limit_q} < FLOOR_AT) ? MIN_L : limit_q - STEP_L;
`endif
        end
    end

    assign o_state   = state_q;
    assign o_running = state_q == S_RUN && !i_pause;
endmodule
